// File: rtl/pipearch_localwrite_pkg.sv
// Shared types and constants for the local BRAM write stage.
// The enum and register indices are shared by the stage and anything that programs it.
package pipearch_localwrite_pkg;

    localparam int DEFAULT_LOG2_MEM_DEPTH = 10;

    localparam int REG_BASE = 0;
    localparam int REG_LEN  = 1;
    localparam int REG_RING = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } t_localwrite_state;

endpackage

// File: rtl/pipearch_localwrite_fifo.sv
// Synchronous line FIFO with an occupancy count. A push is dropped when the FIFO is full.
// Push and pop in the same cycle are both honoured; read data is the head entry.
module pipearch_localwrite_fifo #(
    parameter int WIDTH      = 512,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam logic [LOG2_DEPTH:0] DEPTH = (LOG2_DEPTH + 1)'(2 ** LOG2_DEPTH);

    logic [WIDTH-1:0]      mem [0:(2**LOG2_DEPTH)-1];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; the pointers and count alone say
    // which entries are valid, and a reset array could not map onto RAM resources.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (LOG2_DEPTH + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (LOG2_DEPTH + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/pipearch_localwrite.sv
// Sink of the DRAM load stage: buffers incoming cache lines and writes them into a local
// BRAM at base + running offset (optionally wrapping in a ring), pulsing op_done at the end.
module pipearch_localwrite
    import pipearch_localwrite_pkg::*;
#(
    parameter int DATA_WIDTH       = 512,
    parameter int LOG2_FIFO_DEPTH  = 4,
    parameter int ALMOSTFULL_SLACK = 6,
    parameter int LOG2_MEM_DEPTH   = DEFAULT_LOG2_MEM_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_start,
    output logic                      op_done,
    input  logic [2:0][31:0]          regs,
    input  logic                      in_we,
    input  logic [DATA_WIDTH-1:0]     in_wdata,
    output logic                      in_almostfull,
    output logic                      mem_we,
    output logic [LOG2_MEM_DEPTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      overflow
);

    localparam logic [LOG2_FIFO_DEPTH:0] AF_LEVEL =
        (LOG2_FIFO_DEPTH + 1)'((2 ** LOG2_FIFO_DEPTH) - ALMOSTFULL_SLACK);

    t_localwrite_state         state;
    logic [LOG2_MEM_DEPTH-1:0] base;
    logic [30:0]               len;
    logic [30:0]               written;
    logic [31:0]               ring;
    logic [31:0]               offset;
    logic [31:0]               offset_next;
    logic                      pop;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [LOG2_FIFO_DEPTH:0]  fifo_count;
    logic [DATA_WIDTH-1:0]     fifo_data;
    logic                      unused_regs;

    // Upper base bits and the top bit of the length word carry no meaning here.
    assign unused_regs = ^{regs[REG_BASE][31:LOG2_MEM_DEPTH], regs[REG_LEN][31]};

    pipearch_localwrite_fifo #(
        .WIDTH      (DATA_WIDTH),
        .LOG2_DEPTH (LOG2_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_we),
        .push_data (in_wdata),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign pop = (state == WRITE) && !fifo_empty && (written < len);

    // NOTE: the default assignment comes first so every path drives offset_next and no latch forms.
    always_comb begin
        offset_next = offset + 32'd1;
        if ((ring != '0) && (offset == ring - 32'd1)) begin
            offset_next = '0;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            base          <= '0;
            len           <= '0;
            ring          <= '0;
            written       <= '0;
            offset        <= '0;
            op_done       <= 1'b0;
            mem_we        <= 1'b0;
            mem_waddr     <= '0;
            mem_wdata     <= '0;
            in_almostfull <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            mem_we        <= pop;
            op_done       <= (state == DONE);
            in_almostfull <= (fifo_count >= AF_LEVEL);
            if (in_we && fifo_full) begin
                overflow <= 1'b1;
            end

            if (pop) begin
                mem_waddr <= base + offset[LOG2_MEM_DEPTH-1:0];
                mem_wdata <= fifo_data;
                written   <= written + 31'd1;
                offset    <= offset_next;
            end

            case (state)
                IDLE: begin
                    if (op_start) begin
                        base    <= regs[REG_BASE][LOG2_MEM_DEPTH-1:0];
                        len     <= regs[REG_LEN][30:0];
                        ring    <= regs[REG_RING];
                        written <= '0;
                        offset  <= '0;
                        state   <= (regs[REG_LEN][30:0] == '0) ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    if (pop && (written == len - 31'd1)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipearch_localwrite.sv
// Scoreboard bench for pipearch_localwrite: the driver pushes expected BRAM writes into a
// queue from an ordering-level model; a negedge monitor pops and compares on every mem_we.
module tb_pipearch_localwrite;

    localparam int DW = 512;
    localparam int MD = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic               op_start;
    logic               op_done;
    logic [2:0][31:0]   regs;
    logic               in_we;
    logic [DW-1:0]      in_wdata;
    logic               in_almostfull;
    logic               mem_we;
    logic [MD-1:0]      mem_waddr;
    logic [DW-1:0]      mem_wdata;
    logic               overflow;

    pipearch_localwrite dut (
        .clk           (clk),
        .reset         (reset),
        .op_start      (op_start),
        .op_done       (op_done),
        .regs          (regs),
        .in_we         (in_we),
        .in_wdata      (in_wdata),
        .in_almostfull (in_almostfull),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [MD-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_q[$];
    exp_t          mon_e;

    int unsigned op_base, op_ring, op_idx, op_remaining;
    int n_checks = 0;
    int n_fail   = 0;
    int op_writes = 0;
    int first_we_cyc, last_we_cyc, done_cyc, start_cyc, first_push_cyc;
    int done_cnt = 0;
    int done_snap = 0;

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // The i-th line of an op lands at base + (i mod ring), truncated to the BRAM depth.
    function automatic logic [MD-1:0] model_addr(int unsigned base, int unsigned ring,
                                                 int unsigned idx);
        int unsigned off;
        off = (ring == 0) ? idx : idx % ring;
        return MD'((base + off) % (1 << MD));
    endfunction

    function automatic void model_feed();
        exp_t e;
        while (op_remaining > 0 && model_q.size() > 0) begin
            e.data = model_q.pop_front();
            e.addr = model_addr(op_base, op_ring, op_idx);
            exp_q.push_back(e);
            op_idx++;
            op_remaining--;
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                check("write_expected", DW'(mem_we), DW'(exp_q.size() > 0));
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("mem_waddr", DW'(mem_waddr), DW'(mon_e.addr));
                    check("mem_wdata", mem_wdata, mon_e.data);
                end
                if (op_writes == 0) first_we_cyc = cyc;
                last_we_cyc = cyc;
                op_writes++;
            end
            if (op_done) begin
                done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(int unsigned base, int unsigned len, int unsigned ring);
        regs[0]      = base;
        regs[1]      = len;
        regs[2]      = ring;
        op_start     = 1'b1;
        start_cyc    = cyc;
        done_snap    = done_cnt;
        op_writes    = 0;
        op_base      = base;
        op_ring      = ring;
        op_idx       = 0;
        op_remaining = len;
        model_feed();
        tick();
        op_start = 1'b0;
    endtask

    task automatic push_lines(int n, bit respect_af, int gap_max, int n_accept);
        logic [DW-1:0] d;
        int guard;
        for (int i = 0; i < n; i++) begin
            if (respect_af) begin
                guard = 0;
                while (in_almostfull && guard < 200) begin
                    tick();
                    guard++;
                end
                if (guard >= 200) check("almostfull_release", DW'(in_almostfull), DW'(0));
            end
            d        = rand_line();
            in_we    = 1'b1;
            in_wdata = d;
            if (i == 0) first_push_cyc = cyc;
            if (i < n_accept) begin
                model_q.push_back(d);
                model_feed();
            end
            tick();
            in_we = 1'b0;
            repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic wait_done(string tag, int unsigned len);
        int guard = 0;
        while (done_cnt == done_snap && guard < 400) begin
            tick();
            guard++;
        end
        check({tag, "_done_seen"}, DW'(done_cnt - done_snap), DW'(1));
        check({tag, "_pending"}, DW'(exp_q.size()), DW'(0));
        check({tag, "_writes"}, DW'(op_writes), DW'(len));
        if (len == 0) check({tag, "_zero_done_lat"}, DW'(done_cyc - start_cyc), DW'(2));
        else          check({tag, "_done_after_last"}, DW'(done_cyc - last_we_cyc), DW'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r_base, r_len, r_ring, extra;
        int guard;

        reset    = 1'b1;
        op_start = 1'b0;
        regs     = '0;
        in_we    = 1'b0;
        in_wdata = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_op_done", DW'(op_done), DW'(0));
        check("rst_mem_we", DW'(mem_we), DW'(0));
        check("rst_almostfull", DW'(in_almostfull), DW'(0));
        check("rst_overflow", DW'(overflow), DW'(0));
        check("rst_mem_waddr", DW'(mem_waddr), DW'(0));
        check("rst_mem_wdata", mem_wdata, DW'(0));
        tick();
        reset = 1'b0;
        tick();

        // Basic sequential writes with first-write latency and back-to-back throughput.
        start_op(32'h10, 8, 0);
        push_lines(8, 1'b1, 0, 8);
        wait_done("basic", 8);
        check("basic_latency", DW'(first_we_cyc - first_push_cyc), DW'(2));
        check("basic_throughput", DW'(last_we_cyc - first_we_cyc), DW'(7));

        // Zero length finishes without writing.
        start_op(32'h55, 0, 0);
        wait_done("zero", 0);
        tick();

        // Ring wrap inside a four-line region.
        start_op(32'h100, 10, 4);
        push_lines(10, 1'b1, 0, 10);
        wait_done("ring", 10);

        // Early data: nine queued lines stay below the threshold, twelve go above it.
        push_lines(9, 1'b0, 0, 9);
        tick();
        check("af_at_9", DW'(in_almostfull), DW'(0));
        push_lines(3, 1'b0, 0, 3);
        tick();
        check("af_at_12", DW'(in_almostfull), DW'(1));
        start_op(32'h300, 12, 0);
        wait_done("early", 12);
        check("early_overflow", DW'(overflow), DW'(0));
        tick();
        tick();
        check("af_drained", DW'(in_almostfull), DW'(0));

        // Seventeen lines into an idle block: the last is dropped and overflow sticks.
        push_lines(17, 1'b0, 0, 16);
        tick();
        check("ovf_set", DW'(overflow), DW'(1));
        start_op(32'h200, 16, 0);
        wait_done("ovf", 16);
        check("ovf_sticky", DW'(overflow), DW'(1));

        // Reset in the middle of a long op, then a fresh short op.
        start_op(32'h20, 20, 0);
        push_lines(8, 1'b1, 0, 8);
        guard = 0;
        while (op_writes < 5 && guard < 200) begin
            tick();
            guard++;
        end
        check("midrst_progress", DW'(op_writes >= 5), DW'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_q.delete();
        exp_q.delete();
        op_remaining = 0;
        @(negedge clk);
        check("midrst_mem_we", DW'(mem_we), DW'(0));
        check("midrst_op_done", DW'(op_done), DW'(0));
        check("midrst_overflow", DW'(overflow), DW'(0));
        tick();
        start_op(32'h40, 3, 0);
        push_lines(3, 1'b1, 1, 3);
        wait_done("postrst", 3);

        // Randomized ops; a few extra lines can stay queued for the following op.
        for (int k = 0; k < 8; k++) begin
            r_base = $urandom_range(0, 1023);
            r_len  = $urandom_range(1, 24);
            case ($urandom_range(0, 3))
                0:       r_ring = 0;
                1:       r_ring = $urandom_range(1, 5);
                2:       r_ring = 2000;
                default: r_ring = $urandom_range(6, 30);
            endcase
            extra = (model_q.size() < 4) ? $urandom_range(0, 2) : 0;
            start_op(r_base, r_len, r_ring);
            push_lines(int'(r_len + extra), 1'b1, 2, int'(r_len + extra));
            wait_done("rand", r_len);
        end
        check("rand_overflow", DW'(overflow), DW'(0));

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
